// File: rtl/modbus_frame_tx.sv
// Modbus RTU response serializer: latches a pre-built response frame, hands it
// MSB-byte-first to uart_byte_tx, then holds the 3.5-character inter-frame silence.
module modbus_frame_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int BIT_CYC   = CLK_FREQ / BAUD_RATE,
  parameter int GAP_CYC   = BIT_CYC * 77 / 2,
  parameter int TO_CYC    = BIT_CYC * 16
) (
  input  logic         sys_clk,
  input  logic         reset_n,
  input  logic         tx_exp_rp_start,
  input  logic         tx_06_rp_start,
  input  logic         tx_03_04_rp_start,
  input  logic [39:0]  exception_seq,
  input  logic [63:0]  code06_response,
  input  logic [103:0] code03_04_response,
  input  logic [2:0]   tx_quantity,
  input  logic         tx_done,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         busy,
  output logic         frame_done,
  output logic         tx_reject,
  output logic         tx_abort
);

  localparam int CNT_MAX = (GAP_CYC > TO_CYC) ? GAP_CYC : TO_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] TO_END  = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [103:0]     r_shift;
  logic [3:0]       r_remain;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       w_len_0304;
  logic             w_q_ok;

  // Length of a 03/04 reply and legality of its register count
  always_comb begin
    w_len_0304 = 4'd5 + {tx_quantity, 1'b0};
    if ((tx_quantity != 3'd0) && (tx_quantity <= 3'd4)) begin
      w_q_ok = 1'b1;
    end else begin
      w_q_ok = 1'b0;
    end
  end

  // Frame sequencer: arbitration, byte handshake, byte timeout and inter-frame gap
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= 104'd0;
      r_remain   <= 4'd0;
      r_cnt      <= '0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tx_reject  <= 1'b0;
      tx_abort   <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      tx_reject  <= 1'b0;
      tx_abort   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_exp_rp_start) begin
            r_shift  <= {exception_seq, 64'd0};
            r_remain <= 4'd5;
            busy     <= 1'b1;
            r_state  <= ST_SEND;
          end else if (tx_06_rp_start) begin
            r_shift  <= {code06_response, 40'd0};
            r_remain <= 4'd8;
            busy     <= 1'b1;
            r_state  <= ST_SEND;
          end else if (tx_03_04_rp_start) begin
            if (w_q_ok) begin
              r_shift  <= code03_04_response;
              r_remain <= w_len_0304;
              busy     <= 1'b1;
              r_state  <= ST_SEND;
            end else begin
              tx_reject <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          tx_start <= 1'b1;
          tx_data  <= r_shift[103:96];
          r_shift  <= {r_shift[95:0], 8'h00};
          r_remain <= r_remain - 4'd1;
          r_cnt    <= '0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (r_remain != 4'd0) begin
              r_state <= ST_SEND;
            end else begin
              frame_done <= 1'b1;
              r_cnt      <= '0;
              r_state    <= ST_GAP;
            end
          end else if (r_cnt == TO_END) begin
            // The UART never answered; give up on the rest of the frame
            tx_abort <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_END) begin
            busy    <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Bench for modbus_frame_tx: a cycle-timestamp model predicts every output each cycle;
// directed frames plus literal timing/byte expectations pin that model.
module tb_modbus_frame_tx;

  localparam int GAP_E = 385;   // 10 cycles/bit * 77 / 2
  localparam int TO_E  = 160;   // 10 cycles/bit * 16
  localparam int NEVER = 32'h7fffffff;

  logic         sys_clk, reset_n;
  logic         tx_exp_rp_start, tx_06_rp_start, tx_03_04_rp_start;
  logic [39:0]  exception_seq;
  logic [63:0]  code06_response;
  logic [103:0] code03_04_response;
  logic [2:0]   tx_quantity;
  logic         tx_done;
  logic         tx_start, busy, frame_done, tx_reject, tx_abort;
  logic [7:0]   tx_data;

  modbus_frame_tx #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .tx_exp_rp_start(tx_exp_rp_start), .tx_06_rp_start(tx_06_rp_start),
    .tx_03_04_rp_start(tx_03_04_rp_start), .exception_seq(exception_seq),
    .code06_response(code06_response), .code03_04_response(code03_04_response),
    .tx_quantity(tx_quantity), .tx_done(tx_done), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy), .frame_done(frame_done),
    .tx_reject(tx_reject), .tx_abort(tx_abort)
  );

  int n_checks = 0, n_err = 0, cyc = 0;
  int t_req, t_first, t_fd, t_ab, t_done, t_busy_fall;
  int n_fd = 0, n_rej = 0, n_ab = 0;
  bit first_pending = 0, prev_busy = 0, resp_en = 1;
  int resp_dly = 3;
  logic [7:0] q_got[$];

  // model: expected-event timestamps and the bytes still owed
  logic [7:0] m_bytes[$];
  logic [7:0] m_last = 8'h00;
  int m_next_start = -1, m_wait_from = 0, m_busy_start = 0, m_busy_end = 0;
  int exp_fd = -1, exp_ab = -1, exp_rj = -1;
  bit m_in_wait = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic m_accept(input logic [103:0] v, input int len);
    m_bytes.delete();
    for (int i = 0; i < len; i++) m_bytes.push_back(v[103 - 8*i -: 8]);
    m_next_start = cyc + 2;
    m_busy_start = cyc + 1;
    m_busy_end   = NEVER;
  endtask

  // Per-cycle compare against the model, then prediction from inputs seen at the next edge
  always @(negedge sys_clk) begin
    if (!reset_n) begin
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pulses", {frame_done, tx_reject, tx_abort}, 3'b000);
      m_bytes.delete();
      m_last = 8'h00; m_next_start = -1; m_in_wait = 0;
      m_busy_start = 0; m_busy_end = 0; exp_fd = -1; exp_ab = -1; exp_rj = -1;
      prev_busy = 0;
    end else begin
      chk("tx_start", tx_start, cyc == m_next_start);
      if (tx_start) begin
        q_got.push_back(tx_data);
        if (first_pending) begin t_first = cyc; first_pending = 0; end
      end
      if (cyc == m_next_start) begin
        if (m_bytes.size() > 0) m_last = m_bytes.pop_front();
        m_in_wait = 1; m_wait_from = cyc; m_next_start = -1;
      end
      chk("tx_data", tx_data, m_last);
      chk("frame_done", frame_done, cyc == exp_fd);
      chk("tx_abort", tx_abort, cyc == exp_ab);
      chk("tx_reject", tx_reject, cyc == exp_rj);
      chk("busy", busy, (cyc >= m_busy_start) && (cyc < m_busy_end));
      if (frame_done) begin t_fd = cyc; n_fd++; end
      if (tx_abort) begin t_ab = cyc; n_ab++; end
      if (tx_reject) n_rej++;
      if (tx_done) t_done = cyc;
      if (prev_busy && !busy) t_busy_fall = cyc;
      prev_busy = busy;

      if (m_in_wait) begin
        if (tx_done) begin
          m_in_wait = 0;
          if (m_bytes.size() > 0) m_next_start = cyc + 2;
          else begin exp_fd = cyc + 1; m_busy_end = cyc + GAP_E + 2; end
        end else if (cyc + 1 - m_wait_from == TO_E) begin
          m_in_wait = 0; m_bytes.delete();
          exp_ab = cyc + 1; m_busy_end = cyc + GAP_E + 2;
        end
      end else if (cyc >= m_busy_end) begin
        if (tx_exp_rp_start) m_accept({exception_seq, 64'd0}, 5);
        else if (tx_06_rp_start) m_accept({code06_response, 40'd0}, 8);
        else if (tx_03_04_rp_start) begin
          if (tx_quantity >= 3'd1 && tx_quantity <= 3'd4)
            m_accept(code03_04_response, 5 + 2 * int'(tx_quantity));
          else exp_rj = cyc + 1;
        end
      end
    end
  end

  // UART stand-in: answers each tx_start with a tx_done pulse after resp_dly cycles
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_start && resp_en) begin
        repeat (resp_dly) @(posedge sys_clk);
        #1 tx_done = 1'b1;
        @(posedge sys_clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // which: 0 exp, 1 06, 2 03/04, 3 all three
  task automatic pulse_raw(input int which);
    @(posedge sys_clk); #1;
    tx_exp_rp_start   = (which == 0) || (which == 3);
    tx_06_rp_start    = (which == 1) || (which == 3);
    tx_03_04_rp_start = (which == 2) || (which == 3);
    @(posedge sys_clk); #1;
    tx_exp_rp_start = 1'b0; tx_06_rp_start = 1'b0; tx_03_04_rp_start = 1'b0;
  endtask

  task automatic pulse_req(input int which);
    q_got.delete();
    @(posedge sys_clk); #1;
    t_req = cyc; first_pending = 1;
    tx_exp_rp_start   = (which == 0) || (which == 3);
    tx_06_rp_start    = (which == 1) || (which == 3);
    tx_03_04_rp_start = (which == 2) || (which == 3);
    @(posedge sys_clk); #1;
    tx_exp_rp_start = 1'b0; tx_06_rp_start = 1'b0; tx_03_04_rp_start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    @(negedge sys_clk);
    while (busy && k < lim) begin @(negedge sys_clk); k++; end
    chk("wait_idle_timeout", busy, 1'b0);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic wait_bytes(input int n, input int lim);
    int k = 0;
    while (q_got.size() < n && k < lim) begin @(negedge sys_clk); k++; end
    chk("wait_bytes_timeout", q_got.size() >= n, 1'b1);
  endtask

  task automatic wait_fd(input int lim);
    int k = 0;
    @(negedge sys_clk);
    while (!frame_done && k < lim) begin @(negedge sys_clk); k++; end
    chk("wait_fd_timeout", frame_done, 1'b1);
  endtask

  task automatic chk_bytes(input string nm, input logic [103:0] v, input int len);
    chk({nm, "_len"}, q_got.size(), len);
    for (int i = 0; i < len; i++)
      if (i < q_got.size()) chk({nm, "_byte"}, q_got[i], v[103 - 8*i -: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, rej0, ab0;
    reset_n = 1'b0;
    tx_exp_rp_start = 1'b0; tx_06_rp_start = 1'b0; tx_03_04_rp_start = 1'b0;
    exception_seq = 40'd0; code06_response = 64'd0; code03_04_response = 104'd0;
    tx_quantity = 3'd0;
    repeat (3) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    // exception frame
    exception_seq = 40'h01_83_02_C0_F1;
    pulse_req(0); wait_idle(2000);
    chk("t1_latency", t_first - t_req, 2);
    chk_bytes("t1", 104'h01_83_02_C0_F1_00_00_00_00_00_00_00_00, 5);
    chk("t1_fd_after_done", t_fd - t_done, 1);
    chk("t1_gap", t_busy_fall - t_fd, 386);

    // 06 echo
    resp_dly = 1;
    code06_response = 64'h01_06_00_01_00_05_18_09;
    pulse_req(1); wait_idle(2000);
    chk_bytes("t2", 104'h01_06_00_01_00_05_18_09_00_00_00_00_00, 8);

    // 03 reply q=1 and q=4, then illegal q
    resp_dly = 2;
    code03_04_response = 104'h01_03_02_00_05_AA_BB_EE_EE_EE_EE_EE_EE;
    tx_quantity = 3'd1;
    pulse_req(2); wait_idle(2000);
    chk_bytes("t3_q1", 104'h01_03_02_00_05_AA_BB_00_00_00_00_00_00, 7);
    code03_04_response = 104'h01_03_08_00_01_00_02_00_03_00_04_C1_D2;
    tx_quantity = 3'd4;
    pulse_req(2); wait_idle(2000);
    chk_bytes("t3_q4", 104'h01_03_08_00_01_00_02_00_03_00_04_C1_D2, 13);
    for (int q = 0; q < 2; q++) begin
      rej0 = n_rej;
      tx_quantity = (q == 0) ? 3'd0 : 3'd5;
      pulse_req(2);
      repeat (5) @(negedge sys_clk);
      chk("t3_reject_pulse", n_rej - rej0, 1);
      chk("t3_reject_nobytes", q_got.size(), 0);
    end

    // arbitration and dropped requests
    resp_dly = 4;
    exception_seq = 40'h11_84_03_12_34;
    tx_quantity = 3'd1;
    fd0 = n_fd;
    pulse_req(3);
    wait_bytes(1, 100);
    pulse_raw(1);
    wait_fd(500);
    pulse_raw(1);
    wait_idle(2000);
    chk_bytes("t4", 104'h11_84_03_12_34_00_00_00_00_00_00_00_00, 5);
    chk("t4_one_frame", n_fd - fd0, 1);

    // byte timeout
    resp_en = 0;
    exception_seq = 40'h01_83_02_C0_F1;
    fd0 = n_fd; ab0 = n_ab;
    pulse_req(0); wait_idle(2000);
    resp_en = 1;
    chk("t5_abort_time", t_ab - t_first, 160);
    chk("t5_abort_count", n_ab - ab0, 1);
    chk("t5_no_fd", n_fd - fd0, 0);
    chk("t5_gap", t_busy_fall - t_ab, 386);
    chk("t5_one_byte", q_got.size(), 1);

    // reset during the 4th byte, then an immediate new frame
    resp_dly = 3;
    code06_response = 64'h01_06_00_01_00_05_18_09;
    pulse_req(1);
    wait_bytes(4, 200);
    @(posedge sys_clk); #1 reset_n = 1'b0;
    @(negedge sys_clk);
    chk("t6_rst_outputs", {tx_start, tx_data, busy, frame_done, tx_reject, tx_abort}, 13'd0);
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge sys_clk);
    exception_seq = 40'h01_83_02_C0_F1;
    pulse_req(0); wait_idle(2000);
    chk("t6_latency", t_first - t_req, 2);
    chk_bytes("t6", 104'h01_83_02_C0_F1_00_00_00_00_00_00_00_00, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
